// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matrix-multiply compute stage.
package matmul_pkg;

  // Compute FSM states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    DRAIN    = 3'd2,
    OUT      = 3'd3,
    DONE     = 3'd4,
    WAIT_CLR = 3'd5
  } state_e;

  // Bits needed to hold a K value in 0..maxk inclusive
  function automatic int k_bits_f(input int maxk);
    return $clog2(maxk + 1);
  endfunction

  // Bits needed to address a rows x cols element store
  function automatic int addr_bits_f(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  // Bits needed for a counter over 0..n-1 (at least one bit)
  function automatic int cnt_bits_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Output width: full product plus growth from summing up to maxk products
  function automatic int outw_f(input int inw, input int maxk);
    return 2 * inw + ((maxk > 1) ? $clog2(maxk) : 1);
  endfunction

endpackage

// File: rtl/matmul_compute_mac.sv
// Signed multiply-accumulate: one product per valid cycle, sign-extended
// into an OUTW-bit accumulator. acc_next already includes the product of
// the current cycle so the caller can capture a finished sum without waiting.
module mac_unit
  import matmul_pkg::*;
#(
  parameter int INW  = 12,
  parameter int OUTW = 27
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   valid,
  input  logic signed [INW-1:0]  a_data,
  input  logic signed [INW-1:0]  b_data,
  output logic signed [OUTW-1:0] acc_next
);

  logic signed [2*INW-1:0] product;
  logic signed [OUTW-1:0]  product_ext;
  logic signed [OUTW-1:0]  acc_reg;

  assign product     = a_data * b_data;
  assign product_ext = OUTW'(product);
  assign acc_next    = valid ? (acc_reg + product_ext) : acc_reg;

  // Accumulator register: cleared at element start, otherwise follows acc_next
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg <= '0;
    end else if (clear) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_next;
    end
  end

endmodule

// File: rtl/matmul_compute.sv
// Compute stage: reads A and B through registered-read memory ports, builds
// each C element by serial MAC, and streams C row-major over AXI-Stream.
module matmul_compute
  import matmul_pkg::*;
#(
  parameter  int INW         = 12,
  parameter  int M           = 7,
  parameter  int N           = 9,
  parameter  int MAXK        = 8,
  parameter  int OUTW        = outw_f(INW, MAXK),
  localparam int K_BITS      = k_bits_f(MAXK),
  localparam int A_ADDR_BITS = addr_bits_f(M, MAXK),
  localparam int B_ADDR_BITS = addr_bits_f(MAXK, N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   matrices_loaded,
  input  logic [K_BITS-1:0]      K,
  output logic [A_ADDR_BITS-1:0] A_read_addr,
  input  logic signed [INW-1:0]  A_data,
  output logic [B_ADDR_BITS-1:0] B_read_addr,
  input  logic signed [INW-1:0]  B_data,
  output logic                   compute_finished,
  output logic [OUTW-1:0]        AXIS_TDATA,
  output logic                   AXIS_TVALID,
  input  logic                   AXIS_TREADY,
  output logic                   AXIS_TLAST
);

  localparam int M_BITS = cnt_bits_f(M);
  localparam int N_BITS = cnt_bits_f(N);

  state_e                 state_reg;
  logic [K_BITS-1:0]      k_reg;
  logic [K_BITS-1:0]      i_reg;
  logic [M_BITS-1:0]      m_reg;
  logic [N_BITS-1:0]      n_reg;
  logic [A_ADDR_BITS-1:0] a_row_base_reg;
  logic [A_ADDR_BITS-1:0] a_addr_reg;
  logic [B_ADDR_BITS-1:0] b_addr_reg;
  logic                   valid_reg;
  logic                   tvalid_reg;
  logic                   tlast_reg;
  logic                   finish_reg;
  logic [OUTW-1:0]        tdata_reg;

  logic signed [OUTW-1:0] acc_next;
  logic                   handshake;
  logic                   n_wrap;
  logic                   last_elem;
  logic                   last_fetch;
  logic                   mac_clear;
  logic [N_BITS-1:0]      n_next;
  logic [M_BITS-1:0]      m_next;
  logic [A_ADDR_BITS-1:0] row_base_next;

  // tvalid_reg is only ever high in OUT, so this is the accept condition
  assign handshake     = tvalid_reg & AXIS_TREADY;
  assign n_wrap        = (n_reg == N_BITS'(N - 1));
  assign last_elem     = n_wrap && (m_reg == M_BITS'(M - 1));
  assign n_next        = n_wrap ? '0 : n_reg + 1'b1;
  assign m_next        = n_wrap ? m_reg + 1'b1 : m_reg;
  assign row_base_next = n_wrap ? a_row_base_reg + A_ADDR_BITS'(k_reg) : a_row_base_reg;
  assign last_fetch    = (i_reg == k_reg - K_BITS'(1));
  // Start every C element (job start or after acceptance) from zero
  assign mac_clear     = (state_reg == IDLE) || handshake;

  assign A_read_addr      = a_addr_reg;
  assign B_read_addr      = b_addr_reg;
  assign compute_finished = finish_reg;
  assign AXIS_TDATA       = tdata_reg;
  assign AXIS_TVALID      = tvalid_reg;
  assign AXIS_TLAST       = tlast_reg;

  mac_unit #(
    .INW  (INW),
    .OUTW (OUTW)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clear    (mac_clear),
    .valid    (valid_reg),
    .a_data   (A_data),
    .b_data   (B_data),
    .acc_next (acc_next)
  );

  // Product-valid flag: memory data returns one cycle after each FETCH address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= (state_reg == FETCH);
    end
  end

  // Control FSM with address counters and the AXIS output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      k_reg          <= '0;
      i_reg          <= '0;
      m_reg          <= '0;
      n_reg          <= '0;
      a_row_base_reg <= '0;
      a_addr_reg     <= '0;
      b_addr_reg     <= '0;
      tvalid_reg     <= 1'b0;
      tlast_reg      <= 1'b0;
      tdata_reg      <= '0;
      finish_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (matrices_loaded) begin
            k_reg          <= K;
            i_reg          <= '0;
            m_reg          <= '0;
            n_reg          <= '0;
            a_row_base_reg <= '0;
            a_addr_reg     <= '0;
            b_addr_reg     <= '0;
            // K=0 has nothing to read; go straight to the empty drain
            state_reg      <= (K == '0) ? DRAIN : FETCH;
          end
        end
        FETCH: begin
          if (last_fetch) begin
            i_reg      <= '0;
            a_addr_reg <= '0;
            b_addr_reg <= '0;
            state_reg  <= DRAIN;
          end else begin
            i_reg      <= i_reg + 1'b1;
            a_addr_reg <= a_addr_reg + 1'b1;
            b_addr_reg <= b_addr_reg + B_ADDR_BITS'(N);
          end
        end
        DRAIN: begin
          // acc_next folds in the final product arriving this cycle
          tdata_reg  <= acc_next;
          tlast_reg  <= last_elem;
          tvalid_reg <= 1'b1;
          state_reg  <= OUT;
        end
        OUT: begin
          if (handshake) begin
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
            tdata_reg  <= '0;
            if (last_elem) begin
              finish_reg <= 1'b1;
              state_reg  <= DONE;
            end else begin
              n_reg          <= n_next;
              m_reg          <= m_next;
              a_row_base_reg <= row_base_next;
              if (k_reg == '0) begin
                state_reg <= DRAIN;
              end else begin
                a_addr_reg <= row_base_next;
                b_addr_reg <= B_ADDR_BITS'(n_next);
                state_reg  <= FETCH;
              end
            end
          end
        end
        DONE: begin
          finish_reg <= 1'b0;
          state_reg  <= WAIT_CLR;
        end
        WAIT_CLR: begin
          // Hold off until the input stage drops its stale load flag
          if (!matrices_loaded) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_compute.sv
// Bench for matmul_compute: behavioural memories feed the read ports and a
// plain-arithmetic matrix product supplies the expected C stream.
module tb_matmul_compute;

  localparam int M    = 7;
  localparam int N    = 9;
  localparam int OUTW = 27;

  typedef logic signed [31:0] v32_t;

  logic              clk;
  logic              reset;
  logic              ml;
  logic [3:0]        k_in;
  logic [5:0]        a_addr;
  logic [6:0]        b_addr;
  logic signed [11:0] a_data;
  logic signed [11:0] b_data;
  logic              fin;
  logic [OUTW-1:0]   tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  logic              s_ml;
  logic [3:0]        s_k;
  logic [3:0]        s_a_addr;
  logic [3:0]        s_b_addr;
  logic signed [11:0] s_a_data;
  logic signed [11:0] s_b_data;
  logic              s_fin;
  logic [OUTW-1:0]   s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic              s_tlast;

  logic signed [11:0] a_mem  [0:63];
  logic signed [11:0] b_mem  [0:127];
  logic signed [11:0] sa_mem [0:15];
  logic signed [11:0] sb_mem [0:15];

  int vectors = 0;
  int errors  = 0;

  matmul_compute dut (
    .clk              (clk),
    .reset            (reset),
    .matrices_loaded  (ml),
    .K                (k_in),
    .A_read_addr      (a_addr),
    .A_data           (a_data),
    .B_read_addr      (b_addr),
    .B_data           (b_data),
    .compute_finished (fin),
    .AXIS_TDATA       (tdata),
    .AXIS_TVALID      (tvalid),
    .AXIS_TREADY      (tready),
    .AXIS_TLAST       (tlast)
  );

  matmul_compute #(.M(2), .N(2)) dut_small (
    .clk              (clk),
    .reset            (reset),
    .matrices_loaded  (s_ml),
    .K                (s_k),
    .A_read_addr      (s_a_addr),
    .A_data           (s_a_data),
    .B_read_addr      (s_b_addr),
    .B_data           (s_b_data),
    .compute_finished (s_fin),
    .AXIS_TDATA       (s_tdata),
    .AXIS_TVALID      (s_tvalid),
    .AXIS_TREADY      (s_tready),
    .AXIS_TLAST       (s_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read memories: data one cycle after address
  always @(posedge clk) begin
    a_data   <= a_mem[a_addr];
    b_data   <= b_mem[b_addr];
    s_a_data <= sa_mem[s_a_addr];
    s_b_data <= sb_mem[s_b_addr];
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no end, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input v32_t obs, input v32_t exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++)  a_mem[i] = 12'($urandom);
    for (int i = 0; i < 128; i++) b_mem[i] = 12'($urandom);
  endtask

  task automatic fill_const(input logic signed [11:0] v);
    for (int i = 0; i < 64; i++)  a_mem[i] = v;
    for (int i = 0; i < 128; i++) b_mem[i] = v;
  endtask

  // Run one job on the default instance; abort_at>=0 returns once that many
  // beats are accepted (job left mid-flight), hold = cycles matrices_loaded
  // stays high after the finish pulse.
  task automatic run_job(input int k, input bit rnd_ready, input int abort_at, input int hold);
    int exp_c [0:M*N-1];
    int beats, last_hs, sum;
    bit fin_seen, prev_stall, prev_last;
    logic [OUTW-1:0] prev_data;
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) begin
        sum = 0;
        for (int kk = 0; kk < k; kk++) sum += int'(a_mem[m*k+kk]) * int'(b_mem[kk*N+n]);
        exp_c[m*N+n] = sum;
      end
    end
    k_in = 4'(k);
    ml = 1'b1;
    beats = 0; last_hs = 0; fin_seen = 0; prev_stall = 0; prev_last = 0; prev_data = '0;
    for (int cyc = 0; cyc < 4000 && !fin_seen; cyc++) begin
      @(negedge clk);
      if (abort_at >= 0 && beats == abort_at) return;
      if (prev_stall) begin
        chk("stall_valid", v32_t'(tvalid), 1);
        chk("stall_data",  v32_t'($signed(tdata)), v32_t'($signed(prev_data)));
        chk("stall_last",  v32_t'(tlast), v32_t'(prev_last));
      end
      if (k == 0) begin
        chk("k0_a_addr", v32_t'(a_addr), 0);
        chk("k0_b_addr", v32_t'(b_addr), 0);
      end
      if (fin) begin
        chk("finish_beats", beats, M*N);
        chk("finish_timing", cyc - last_hs, 1);
        fin_seen = 1;
      end
      tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
      if (tvalid && tready) begin
        if (beats < M*N) begin
          chk("tdata", v32_t'($signed(tdata)), exp_c[beats]);
          chk("tlast", v32_t'(tlast), (beats == M*N-1) ? 1 : 0);
          if (!rnd_ready && beats > 0) chk("beat_period", cyc - last_hs, k + 2);
          $display("beat k=%0d idx=%0d data=%0d last=%0d", k, beats, $signed(tdata), tlast);
        end else begin
          chk("extra_beat", beats, M*N - 1);
        end
        last_hs = cyc;
        beats++;
      end
    end
    if (!fin_seen) chk("finish_timeout", 0, 1);
    @(negedge clk);
    chk("finish_single", v32_t'(fin), 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("wait_clr_valid", v32_t'(tvalid), 0);
      chk("wait_clr_fin",   v32_t'(fin), 0);
    end
    ml = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int s_exp [0:3];
    int idx, last_hs;
    bit done;
    reset = 1'b0; ml = 1'b0; k_in = '0; tready = 1'b0;
    s_ml = 1'b0; s_k = 4'd1; s_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin sa_mem[i] = '0; sb_mem[i] = '0; end
    fill_const(12'sd0);
    repeat (3) @(negedge clk);
    chk("rst_tvalid", v32_t'(tvalid), 0);
    chk("rst_tlast",  v32_t'(tlast), 0);
    chk("rst_tdata",  v32_t'($signed(tdata)), 0);
    chk("rst_fin",    v32_t'(fin), 0);
    chk("rst_a_addr", v32_t'(a_addr), 0);
    chk("rst_b_addr", v32_t'(b_addr), 0);
    reset = 1'b1;
    @(negedge clk);

    // 2x2 instance, K=1, A=[3;-4], B=[5 6]
    sa_mem[0] = 12'sd3; sa_mem[1] = -12'sd4;
    sb_mem[0] = 12'sd5; sb_mem[1] = 12'sd6;
    s_exp = '{15, 18, -20, -24};
    s_ml = 1'b1;
    idx = 0; last_hs = 0; done = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (s_fin) begin
        chk("small_finish_beats", idx, 4);
        chk("small_finish_timing", cyc - last_hs, 1);
        done = 1;
      end
      if (s_tvalid) begin
        if (idx < 4) begin
          chk("small_tdata", v32_t'($signed(s_tdata)), s_exp[idx]);
          chk("small_tlast", v32_t'(s_tlast), (idx == 3) ? 1 : 0);
          $display("small beat idx=%0d data=%0d last=%0d", idx, $signed(s_tdata), s_tlast);
        end else begin
          chk("small_extra_beat", idx, 3);
        end
        last_hs = cyc;
        idx++;
      end
    end
    if (!done) chk("small_finish_timeout", 0, 1);
    @(negedge clk);
    chk("small_finish_single", v32_t'(s_fin), 0);
    s_ml = 1'b0;

    // Worst-case magnitude, full K, TREADY held high
    fill_const(-12'sd2048);
    run_job(8, 1'b0, -1, 0);

    // K=2 random data with random backpressure
    fill_random();
    run_job(2, 1'b1, -1, 0);

    // K=0: all zeros, no reads
    fill_random();
    run_job(0, 1'b0, -1, 0);

    // Reset while C(1,3) is being computed, then restart with load still high
    fill_random();
    run_job(4, 1'b0, N + 3, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_tvalid", v32_t'(tvalid), 0);
    chk("mid_rst_tlast",  v32_t'(tlast), 0);
    chk("mid_rst_tdata",  v32_t'($signed(tdata)), 0);
    chk("mid_rst_fin",    v32_t'(fin), 0);
    chk("mid_rst_a_addr", v32_t'(a_addr), 0);
    chk("mid_rst_b_addr", v32_t'(b_addr), 0);
    @(negedge clk);
    reset = 1'b1;
    run_job(4, 1'b0, -1, 0);

    // Back-to-back jobs with the load flag held past finish
    fill_random();
    run_job(3, 1'b0, -1, 2);
    fill_random();
    run_job(5, 1'b0, -1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
